// File: rtl/mshr_repair_controller_pkg.sv
// Shared types and constants for the MSHR repair sequencer and the D-cache
// store path: line geometry, repair FSM states and the latched repair context.
package mshr_repair_controller_pkg;

  localparam int unsigned LINE_BYTES  = 16;
  localparam int unsigned ROB_ENTRIES = 16;
  localparam int unsigned ROB_IDX_W   = $clog2(ROB_ENTRIES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } repair_state_e;

  typedef struct packed {
    logic [31:0]          addr;
    logic [31:0]          data;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 is_store;
  } repair_ctx_t;

  // Clear the byte-offset bits of an address for a power-of-two line size.
  function automatic logic [31:0] line_align(input logic [31:0] addr,
                                             input int unsigned line_bytes);
    return addr & ~(32'(line_bytes) - 32'd1);
  endfunction

endpackage

// File: rtl/mshr_repair_controller_if.sv
// Next-level memory channel: one line-read request handshake plus the
// returning line. The repair controller is the master.
interface mshr_repair_controller_if #(
  parameter int unsigned LINE_BYTES = 16
) ();

  logic                    mem_req_vld;
  logic                    mem_req_rdy;
  logic [31:0]             mem_req_addr;
  logic                    mem_resp_vld;
  logic [8*LINE_BYTES-1:0] mem_resp_data;

  modport master (
    output mem_req_vld,
    output mem_req_addr,
    input  mem_req_rdy,
    input  mem_resp_vld,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_vld,
    input  mem_req_addr,
    output mem_req_rdy,
    output mem_resp_vld,
    output mem_resp_data
  );

endinterface

// File: rtl/mshr_repair_controller_line_word_merge.sv
// Combinational word access into a cache line: reads the 32-bit word at a
// word offset and produces the line with that word replaced. Shared with the
// D-cache store path.
module line_word_merge #(
  parameter  int unsigned LINE_BYTES = 16,
  localparam int unsigned WORDS      = LINE_BYTES / 4,
  localparam int unsigned WOFF_W     = $clog2(WORDS)
) (
  input  logic [8*LINE_BYTES-1:0] line_i,
  input  logic [WOFF_W-1:0]       word_off_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o,
  output logic [8*LINE_BYTES-1:0] line_o
);

  // Select the addressed word and splice the write data into its slot.
  always_comb begin
    rdata_o = 32'd0;
    line_o  = line_i;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (word_off_i == WOFF_W'(i)) begin
        rdata_o            = line_i[32*i +: 32];
        line_o[32*i +: 32] = wdata_i;
      end else begin
        line_o[32*i +: 32] = line_i[32*i +: 32];
      end
    end
  end

endmodule

// File: rtl/mshr_repair_controller.sv
// MSHR repair sequencer: accepts one repair at a time, reads the whole line
// from next-level memory, then fills the D-cache and either writes the missed
// word back to the ROB (load) or merges store data and reports store done.
// A flush while the memory read is in flight cannot cancel it; the response
// is consumed and only the completion pulse survives.
module mshr_repair_controller #(
  parameter  int unsigned LINE_BYTES  = mshr_repair_controller_pkg::LINE_BYTES,
  parameter  int unsigned ROB_ENTRIES = mshr_repair_controller_pkg::ROB_ENTRIES,
  localparam int unsigned ROB_IDX_W   = $clog2(ROB_ENTRIES)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        repair_req_i,
  input  logic [31:0]                 repair_req_addr_i,
  input  logic [31:0]                 repair_req_data_i,
  input  logic [ROB_IDX_W-1:0]        repair_req_rob_idx_i,
  input  logic                        repair_is_store_i,
  output logic                        repair_ack_o,
  output logic                        repair_complete_o,
  mshr_repair_controller_if.master    mem_if,
  output logic                        fill_vld_o,
  output logic [31:0]                 fill_addr_o,
  output logic [8*LINE_BYTES-1:0]     fill_line_o,
  output logic                        ld_wb_vld_o,
  output logic [ROB_IDX_W-1:0]        ld_wb_rob_idx_o,
  output logic [31:0]                 ld_wb_data_o,
  output logic                        st_done_vld_o,
  output logic [ROB_IDX_W-1:0]        st_done_rob_idx_o,
  output logic                        busy_o
);

  import mshr_repair_controller_pkg::*;

  localparam int unsigned LINE_W = 8 * LINE_BYTES;
  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned WOFF_W = OFF_W - 2;

  repair_state_e     state_r;
  repair_state_e     state_nxt_s;
  repair_ctx_t       ctx_r;
  logic [LINE_W-1:0] line_r;
  logic              squash_r;

  logic              ack_s;
  logic              deliver_s;
  logic [31:0]       line_addr_s;
  logic [WOFF_W-1:0] word_off_s;
  logic [31:0]       rd_word_s;
  logic [LINE_W-1:0] merged_line_s;
  logic              unused_addr_s;

  // Accept only from IDLE and never while the pipeline is being flushed.
  assign ack_s        = (state_r == IDLE) & repair_req_i & ~flush_i;
  assign repair_ack_o = ack_s;

  assign line_addr_s   = line_align(ctx_r.addr, LINE_BYTES);
  assign word_off_s    = ctx_r.addr[OFF_W-1:2];
  assign unused_addr_s = ^ctx_r.addr[1:0];

  // Side effects of the response are dropped if a flush hit this repair.
  assign deliver_s = (state_r == RESP) & ~(squash_r | flush_i);

  line_word_merge #(
    .LINE_BYTES (LINE_BYTES)
  ) u_line_word_merge (
    .line_i     (line_r),
    .word_off_i (word_off_s),
    .wdata_i    (ctx_r.data),
    .rdata_o    (rd_word_s),
    .line_o     (merged_line_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: accept, issue the line read, wait for data, retire.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (ack_s) state_nxt_s = REQ;
        else       state_nxt_s = IDLE;
      end
      REQ: begin
        if (mem_if.mem_req_rdy) state_nxt_s = WAIT;
        else                    state_nxt_s = REQ;
      end
      WAIT: begin
        if (mem_if.mem_resp_vld) state_nxt_s = RESP;
        else                     state_nxt_s = WAIT;
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Latch the repair context on accept and the memory line when it returns.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctx_r  <= '0;
      line_r <= '0;
    end else begin
      if (ack_s) begin
        ctx_r.addr     <= repair_req_addr_i;
        ctx_r.data     <= repair_req_data_i;
        ctx_r.rob_idx  <= repair_req_rob_idx_i;
        ctx_r.is_store <= repair_is_store_i;
      end
      if ((state_r == WAIT) && mem_if.mem_resp_vld) begin
        line_r <= mem_if.mem_resp_data;
      end
    end
  end

  // Remember a flush seen while the read is in flight; forget it on retire.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      squash_r <= 1'b0;
    end else if (state_r == RESP) begin
      squash_r <= 1'b0;
    end else if (((state_r == REQ) || (state_r == WAIT)) && flush_i) begin
      squash_r <= 1'b1;
    end
  end

  // FSM outputs decoded from the registered state and context.
  always_comb begin
    busy_o              = 1'b0;
    mem_if.mem_req_vld  = 1'b0;
    mem_if.mem_req_addr = 32'd0;
    repair_complete_o   = 1'b0;
    fill_vld_o          = 1'b0;
    fill_addr_o         = 32'd0;
    fill_line_o         = '0;
    ld_wb_vld_o         = 1'b0;
    ld_wb_rob_idx_o     = '0;
    ld_wb_data_o        = 32'd0;
    st_done_vld_o       = 1'b0;
    st_done_rob_idx_o   = '0;
    case (state_r)
      IDLE: busy_o = 1'b0;
      REQ: begin
        busy_o              = 1'b1;
        mem_if.mem_req_vld  = 1'b1;
        mem_if.mem_req_addr = line_addr_s;
      end
      WAIT: busy_o = 1'b1;
      RESP: begin
        busy_o            = 1'b1;
        repair_complete_o = 1'b1;
        if (deliver_s) begin
          fill_vld_o  = 1'b1;
          fill_addr_o = line_addr_s;
          if (ctx_r.is_store) begin
            fill_line_o       = merged_line_s;
            st_done_vld_o     = 1'b1;
            st_done_rob_idx_o = ctx_r.rob_idx;
          end else begin
            fill_line_o     = line_r;
            ld_wb_vld_o     = 1'b1;
            ld_wb_rob_idx_o = ctx_r.rob_idx;
            ld_wb_data_o    = rd_word_s;
          end
        end else begin
          fill_vld_o = 1'b0;
        end
      end
      default: busy_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mshr_repair_controller.sv
// Scoreboard bench for the MSHR repair controller: a driver issues directed
// and random repairs and pushes model expectations; a negedge monitor checks
// every DUT output against them.
module tb_mshr_repair_controller;
  import mshr_repair_controller_pkg::*;

  localparam int unsigned LW = 8 * LINE_BYTES;
  localparam int unsigned NW = LINE_BYTES / 4;

  typedef struct {
    logic [31:0]          addr;
    logic [31:0]          data;
    logic [ROB_IDX_W-1:0] rob;
    logic                 is_store;
    logic [LW-1:0]        line;
    int                   rdy_dly;
    int                   resp_dly;
    int                   flush_ph;   // 0 none, 1 REQ, 2 WAIT, 3 RESP
    int                   idle_flush;
    bit                   hold;
  } txn_t;

  typedef struct {
    logic                 fill_vld;
    logic                 ld_vld;
    logic                 st_vld;
    logic [31:0]          fill_addr;
    logic [31:0]          ld_data;
    logic [LW-1:0]        fill_line;
    logic [ROB_IDX_W-1:0] rob;
  } exp_t;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 flush_i;
  logic                 repair_req_i;
  logic [31:0]          repair_req_addr_i;
  logic [31:0]          repair_req_data_i;
  logic [ROB_IDX_W-1:0] repair_req_rob_idx_i;
  logic                 repair_is_store_i;
  logic                 repair_ack_o;
  logic                 repair_complete_o;
  logic                 fill_vld_o;
  logic [31:0]          fill_addr_o;
  logic [LW-1:0]        fill_line_o;
  logic                 ld_wb_vld_o;
  logic [ROB_IDX_W-1:0] ld_wb_rob_idx_o;
  logic [31:0]          ld_wb_data_o;
  logic                 st_done_vld_o;
  logic [ROB_IDX_W-1:0] st_done_rob_idx_o;
  logic                 busy_o;

  mshr_repair_controller_if #(.LINE_BYTES(LINE_BYTES)) mem_if ();

  mshr_repair_controller dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .flush_i              (flush_i),
    .repair_req_i         (repair_req_i),
    .repair_req_addr_i    (repair_req_addr_i),
    .repair_req_data_i    (repair_req_data_i),
    .repair_req_rob_idx_i (repair_req_rob_idx_i),
    .repair_is_store_i    (repair_is_store_i),
    .repair_ack_o         (repair_ack_o),
    .repair_complete_o    (repair_complete_o),
    .mem_if               (mem_if.master),
    .fill_vld_o           (fill_vld_o),
    .fill_addr_o          (fill_addr_o),
    .fill_line_o          (fill_line_o),
    .ld_wb_vld_o          (ld_wb_vld_o),
    .ld_wb_rob_idx_o      (ld_wb_rob_idx_o),
    .ld_wb_data_o         (ld_wb_data_o),
    .st_done_vld_o        (st_done_vld_o),
    .st_done_rob_idx_o    (st_done_rob_idx_o),
    .busy_o               (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cpl_cyc = 0;
  int last_ack_cyc = 0;
  logic tb_busy = 1'b0;
  logic tb_in_req = 1'b0;
  logic tb_in_resp = 1'b0;
  exp_t exp_q[$];
  logic [31:0] req_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < NW; i++) l[32*i +: 32] = $urandom();
    return l;
  endfunction

  // Reference: treat the line as an array of words, pick/replace by byte offset.
  function automatic exp_t model(input txn_t t);
    exp_t        e;
    logic [31:0] words [NW];
    int unsigned w;
    bit          deliver;
    deliver = (t.flush_ph == 0);
    for (int i = 0; i < NW; i++) words[i] = t.line[32*i +: 32];
    w = (t.addr % LINE_BYTES) / 4;
    e.fill_vld  = deliver;
    e.ld_vld    = deliver && !t.is_store;
    e.st_vld    = deliver && t.is_store;
    e.fill_addr = t.addr - (t.addr % LINE_BYTES);
    e.ld_data   = words[w];
    e.rob       = t.rob;
    if (t.is_store) words[w] = t.data;
    for (int i = 0; i < NW; i++) e.fill_line[32*i +: 32] = words[i];
    return e;
  endfunction

  function automatic txn_t mk(input logic [31:0] addr, input logic [31:0] data,
                              input int rob, input bit st, input logic [LW-1:0] line);
    txn_t t;
    t.addr = addr; t.data = data; t.rob = ROB_IDX_W'(rob); t.is_store = st; t.line = line;
    t.rdy_dly = 0; t.resp_dly = 0; t.flush_ph = 0; t.idle_flush = 0; t.hold = 1'b0;
    return t;
  endfunction

  // Drive one repair from IDLE (entered at posedge+1) back to IDLE.
  task automatic run_txn(input txn_t t);
    bit acked;
    repair_req_addr_i    = t.addr;
    repair_req_data_i    = t.data;
    repair_req_rob_idx_i = t.rob;
    repair_is_store_i    = t.is_store;
    repair_req_i         = 1'b1;
    if (t.idle_flush > 0) begin
      flush_i = 1'b1;
      repeat (t.idle_flush) @(posedge clk_i);
      #1 flush_i = 1'b0;
    end
    acked = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      if (repair_ack_o) begin
        acked = 1'b1;
        break;
      end
    end
    if (!acked) begin
      fail("ack_timeout", "repair_ack_o got 0 for 16 cycles, expected 1");
      repair_req_i = 1'b0;
      @(posedge clk_i); #1;
      return;
    end
    last_ack_cyc = cyc;
    req_q.push_back(t.addr - (t.addr % LINE_BYTES));
    exp_q.push_back(model(t));
    @(posedge clk_i); #1;  // REQ
    tb_busy = 1'b1; tb_in_req = 1'b1;
    repair_req_i = t.hold;
    flush_i = (t.flush_ph == 1);
    for (int i = 0; i < t.rdy_dly; i++) begin
      mem_if.mem_req_rdy   = 1'b0;
      mem_if.mem_resp_vld  = 1'($urandom_range(0, 1));
      mem_if.mem_resp_data = rand_line();
      if (!t.hold) repair_req_i = 1'($urandom_range(0, 1));
      @(posedge clk_i); #1;
      flush_i = 1'b0;
    end
    mem_if.mem_resp_vld = 1'b0;
    mem_if.mem_req_rdy  = 1'b1;
    repair_req_i = t.hold;
    @(posedge clk_i); #1;  // WAIT
    tb_in_req = 1'b0;
    mem_if.mem_req_rdy = 1'b0;
    flush_i = (t.flush_ph == 2);
    for (int i = 0; i < t.resp_dly; i++) begin
      @(posedge clk_i); #1;
      flush_i = 1'b0;
    end
    mem_if.mem_resp_vld  = 1'b1;
    mem_if.mem_resp_data = t.line;
    @(posedge clk_i); #1;  // RESP
    tb_in_resp = 1'b1;
    mem_if.mem_resp_vld = 1'b0;
    flush_i = (t.flush_ph == 3);
    @(posedge clk_i); #1;  // IDLE
    tb_in_resp = 1'b0; tb_busy = 1'b0; flush_i = 1'b0;
  endtask

  // Monitor: compare DUT outputs with the driver-tracked phase and the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        check("reset_strobes", {repair_ack_o, repair_complete_o, mem_if.mem_req_vld, fill_vld_o,
                                ld_wb_vld_o, st_done_vld_o, busy_o}, '0);
        check("reset_fields", {mem_if.mem_req_addr, fill_addr_o, ld_wb_data_o,
                               ld_wb_rob_idx_o, st_done_rob_idx_o}, '0);
        check("reset_fill_line", fill_line_o, '0);
      end else begin
        check("busy", busy_o, tb_busy);
        check("ack", repair_ack_o, repair_req_i & ~flush_i & ~tb_busy);
        check("mem_req_vld", mem_if.mem_req_vld, tb_in_req);
        if (mem_if.mem_req_vld) begin
          if (req_q.size() == 0) fail("mem_req_unexpected", "mem_req_vld got 1, expected 0");
          else begin
            check("mem_req_addr", mem_if.mem_req_addr, req_q[0]);
            if (mem_if.mem_req_rdy) void'(req_q.pop_front());
          end
        end
        check("complete", repair_complete_o, tb_in_resp);
        if (repair_complete_o) begin
          last_cpl_cyc = cyc;
          if (exp_q.size() == 0) fail("complete_unexpected", "repair_complete_o got 1, expected 0");
          else begin
            e = exp_q.pop_front();
            check("fill_vld", fill_vld_o, e.fill_vld);
            check("ld_wb_vld", ld_wb_vld_o, e.ld_vld);
            check("st_done_vld", st_done_vld_o, e.st_vld);
            if (e.fill_vld) begin
              check("fill_addr", fill_addr_o, e.fill_addr);
              check("fill_line", fill_line_o, e.fill_line);
            end
            if (e.ld_vld) begin
              check("ld_wb_data", ld_wb_data_o, e.ld_data);
              check("ld_wb_rob", ld_wb_rob_idx_o, e.rob);
            end
            if (e.st_vld) check("st_done_rob", st_done_rob_idx_o, e.rob);
          end
        end else begin
          check("idle_strobes", {fill_vld_o, ld_wb_vld_o, st_done_vld_o}, '0);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation still running at 400000 time units, expected to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    txn_t t;
    int   first_cpl;
    logic [LW-1:0] l;
    rst_ni = 1'b0; flush_i = 1'b0; repair_req_i = 1'b0;
    repair_req_addr_i = 32'd0; repair_req_data_i = 32'd0;
    repair_req_rob_idx_i = '0; repair_is_store_i = 1'b0;
    mem_if.mem_req_rdy = 1'b0; mem_if.mem_resp_vld = 1'b1; mem_if.mem_resp_data = rand_line();
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    // stale response right after reset must be ignored
    @(posedge clk_i); #1 mem_if.mem_resp_vld = 1'b0;
    @(posedge clk_i); #1;

    // load repair: word 2 of line 0x1230
    l = rand_line(); l[64 +: 32] = 32'hDEAD_BEEF;
    run_txn(mk(32'h0000_1238, 32'h0, 5, 1'b0, l));

    // store repair into an all-zero line at word 0
    run_txn(mk(32'h0000_0040, 32'h1234_5678, 9, 1'b1, '0));

    // backpressure with a competing request held high
    t = mk(32'h0000_2A34, 32'h0, 3, 1'b0, rand_line());
    t.rdy_dly = 4; t.hold = 1'b1;
    run_txn(t);

    // flush in WAIT, then the next request is taken in the IDLE cycle
    t = mk(32'h0000_3308, 32'hCAFE_0001, 7, 1'b1, rand_line());
    t.flush_ph = 2; t.resp_dly = 2; t.hold = 1'b1;
    run_txn(t);
    first_cpl = last_cpl_cyc;
    run_txn(mk(32'h0000_330C, 32'h0, 8, 1'b0, rand_line()));
    check("ack_after_flush_gap", 32'(last_ack_cyc - first_cpl), 32'd1);

    // back-to-back load then store with the request held high
    t = mk(32'h0000_5004, 32'h0, 1, 1'b0, rand_line());
    t.hold = 1'b1;
    run_txn(t);
    first_cpl = last_cpl_cyc;
    run_txn(mk(32'h0000_600C, 32'hA5A5_5A5A, 2, 1'b1, rand_line()));
    check("b2b_ack_gap", 32'(last_ack_cyc - first_cpl), 32'd1);

    // flush in IDLE holds off the ack
    t = mk(32'h0000_7000, 32'h0, 4, 1'b0, rand_line());
    t.idle_flush = 3;
    run_txn(t);

    // reset in WAIT, then a late response
    repair_req_addr_i = 32'h0000_8888; repair_req_rob_idx_i = ROB_IDX_W'(6);
    repair_is_store_i = 1'b0; repair_req_i = 1'b1;
    @(negedge clk_i);
    if (!repair_ack_o) fail("reset_txn_ack", "repair_ack_o got 0, expected 1");
    req_q.push_back(32'h0000_8880);
    @(posedge clk_i); #1;
    tb_busy = 1'b1; tb_in_req = 1'b1; repair_req_i = 1'b0; mem_if.mem_req_rdy = 1'b1;
    @(posedge clk_i); #1;
    tb_in_req = 1'b0; mem_if.mem_req_rdy = 1'b0;
    #2 rst_ni = 1'b0; tb_busy = 1'b0;
    exp_q.delete(); req_q.delete();
    @(posedge clk_i); #1 rst_ni = 1'b1;
    mem_if.mem_resp_vld = 1'b1; mem_if.mem_resp_data = rand_line();
    repeat (2) @(posedge clk_i);
    #1 mem_if.mem_resp_vld = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;

    // randomized repairs
    for (int n = 0; n < 50; n++) begin
      t = mk($urandom(), $urandom(), int'($urandom_range(0, ROB_ENTRIES - 1)),
             1'($urandom_range(0, 1)), rand_line());
      t.rdy_dly    = int'($urandom_range(0, 4));
      t.resp_dly   = int'($urandom_range(0, 4));
      t.flush_ph   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      t.idle_flush = int'($urandom_range(0, 2));
      t.hold       = 1'($urandom_range(0, 1));
      run_txn(t);
    end
    repair_req_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
